// File: rtl/floating_point_accumulator.sv
// floating_point_accumulator
//   Sequential IEEE-754 accumulator. Reduces a burst of len_in operands, each
//   added or subtracted, into one sum and returns it over a valid/ready
//   handshake. The combinational adder floating_point_addition is in this file.
//
// Ports (floating_point_accumulator)
//   clk_in, rst_n_in       rising-edge clock, asynchronous active-low reset
//   start_in, len_in       begin a burst of len_in operands (sampled in IDLE only)
//   data_in, opcode_in     operand and its operation (0 add, 1 subtract)
//   data_valid_in          operand valid; data_ready_out accepts it
//   result_out             final sum, held while result_valid_out is high
//   result_valid_out       result available; result_ready_in consumes it
//   busy_out               high whenever a burst or result is pending
//   special_out            sticky: accumulator exponent hit all-ones this burst
//
// Ports (floating_point_addition)
//   floating1_in, floating2_in  operands; opcode_in=1 negates floating2_in
//   floating_addition_out       round-to-nearest-even sum

module floating_point_addition #(
   parameter int DATA_WIDTH = 32,
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] floating1_in,
   input  logic [DATA_WIDTH-1:0] floating2_in,
   input  logic                  opcode_in,
   output logic [DATA_WIDTH-1:0] floating_addition_out
);
   // hidden bit + fraction + guard/round/sticky
   localparam int XW = MENT_WIDTH + 4;
   localparam int EW = EXPO_WIDTH + 2;
   localparam logic [EXPO_WIDTH-1:0] EXP_ONES = '1;

   // Round-to-nearest-even of the normalized significand; the extra MSB
   // catches the carry out of rounding.
   function automatic logic [MENT_WIDTH+1:0] round_rne(input logic [XW-1:0] m);
      logic up;
      up = m[2] & (m[1] | m[0] | m[3]);
      return {1'b0, m[XW-1:3]} + {{(MENT_WIDTH+1){1'b0}}, up};
   endfunction

   logic                  sa, sb, sign_big, sign_small, swap, lost, hidden;
   logic                  a_nan, b_nan, a_inf, b_inf;
   logic [EXPO_WIDTH-1:0] ea, eb, e_big, e_small, diff;
   logic [MENT_WIDTH-1:0] fa, fb, f_big, f_small, frac;
   logic [XW-1:0]         m_big, m_small, m_sh, norm;
   logic [XW:0]           sum;
   logic [EW-1:0]         expo;
   logic [MENT_WIDTH+1:0] rnd;

   always_comb begin
      sa = floating1_in[DATA_WIDTH-1];
      ea = floating1_in[DATA_WIDTH-2:MENT_WIDTH];
      fa = floating1_in[MENT_WIDTH-1:0];
      sb = floating2_in[DATA_WIDTH-1] ^ opcode_in;
      eb = floating2_in[DATA_WIDTH-2:MENT_WIDTH];
      fb = floating2_in[MENT_WIDTH-1:0];
      a_nan = (ea == EXP_ONES) && (fa != '0);
      b_nan = (eb == EXP_ONES) && (fb != '0);
      a_inf = (ea == EXP_ONES) && (fa == '0);
      b_inf = (eb == EXP_ONES) && (fb == '0);

      // Order operands by magnitude so the subtraction never goes negative.
      swap       = {eb, fb} > {ea, fa};
      sign_big   = swap ? sb : sa;
      sign_small = swap ? sa : sb;
      e_big      = swap ? eb : ea;
      e_small    = swap ? ea : eb;
      f_big      = swap ? fb : fa;
      f_small    = swap ? fa : fb;
      m_big      = {e_big != '0, f_big, 3'b000};
      m_small    = {e_small != '0, f_small, 3'b000};
      // Denormals share the exponent of the smallest normal.
      if (e_big == '0)   e_big   = EXPO_WIDTH'(1);
      if (e_small == '0) e_small = EXPO_WIDTH'(1);
      diff = e_big - e_small;

      // Alignment shift; bits shifted out collapse into the sticky bit.
      m_sh    = m_small >> diff;
      lost    = |(m_small & ~({XW{1'b1}} << diff));
      m_sh[0] = m_sh[0] | lost;

      if (sign_big == sign_small) sum = {1'b0, m_big} + {1'b0, m_sh};
      else                        sum = {1'b0, m_big} - {1'b0, m_sh};

      expo = {2'b00, e_big};
      if (sum[XW]) begin
         norm = {sum[XW:2], sum[1] | sum[0]};
         expo = expo + EW'(1);
      end else begin
         norm = sum[XW-1:0];
      end
      // Left-normalize after cancellation, stopping at the denormal exponent.
      for (int i = 0; i < XW; i++) begin
         if (!norm[XW-1] && (expo > EW'(1))) begin
            norm = norm << 1;
            expo = expo - EW'(1);
         end
      end

      rnd = round_rne(norm);
      if (rnd[MENT_WIDTH+1]) begin
         expo   = expo + EW'(1);
         frac   = rnd[MENT_WIDTH:1];
         hidden = 1'b1;
      end else begin
         frac   = rnd[MENT_WIDTH-1:0];
         hidden = rnd[MENT_WIDTH];
      end
      if (!hidden) expo = '0;

      floating_addition_out = {sign_big, expo[EXPO_WIDTH-1:0], frac};
      if (expo >= {2'b00, EXP_ONES})
         floating_addition_out = {sign_big, EXP_ONES, {MENT_WIDTH{1'b0}}};
      // Exact cancellation gives +0; only -0 + -0 keeps the minus sign.
      if (sum == '0)
         floating_addition_out = {sign_big & sign_small, {(DATA_WIDTH-1){1'b0}}};
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
         floating_addition_out = {1'b0, EXP_ONES, 1'b1, {(MENT_WIDTH-1){1'b0}}};
      else if (a_inf)
         floating_addition_out = {sa, EXP_ONES, {MENT_WIDTH{1'b0}}};
      else if (b_inf)
         floating_addition_out = {sb, EXP_ONES, {MENT_WIDTH{1'b0}}};
   end
endmodule

module floating_point_accumulator #(
   parameter int DATA_WIDTH  = 32,
   parameter int MENT_WIDTH  = 23,
   parameter int EXPO_WIDTH  = 8,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   start_in,
   input  logic [COUNT_WIDTH-1:0] len_in,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   opcode_in,
   input  logic                   data_valid_in,
   output logic                   data_ready_out,
   output logic [DATA_WIDTH-1:0]  result_out,
   output logic                   result_valid_out,
   input  logic                   result_ready_in,
   output logic                   busy_out,
   output logic                   special_out
);
   typedef enum logic [1:0] {IDLE, FIRST, ACCUM, DONE} state_t;

   state_t                 state, state_nxt;
   logic [DATA_WIDTH-1:0]  acc, acc_nxt, sum;
   logic [COUNT_WIDTH-1:0] remaining, remaining_nxt;
   logic                   special, special_nxt;

   floating_point_addition #(
      .DATA_WIDTH(DATA_WIDTH),
      .MENT_WIDTH(MENT_WIDTH),
      .EXPO_WIDTH(EXPO_WIDTH)
   ) u_add (
      .floating1_in         (acc),
      .floating2_in         (data_in),
      .opcode_in            (opcode_in),
      .floating_addition_out(sum)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         special   <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         remaining <= remaining_nxt;
         special   <= special_nxt;
      end
   end

   // In FIRST/ACCUM data_ready_out is 1, so data_valid_in alone marks a beat.
   always_comb begin
      state_nxt        = state;
      acc_nxt          = acc;
      remaining_nxt    = remaining;
      special_nxt      = special;
      data_ready_out   = 1'b0;
      result_valid_out = 1'b0;
      result_out       = '0;
      unique case (state)
         IDLE: begin
            if (start_in) begin
               if (len_in == '0) begin
                  acc_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  remaining_nxt = len_in;
                  special_nxt   = 1'b0;
                  state_nxt     = FIRST;
               end
            end
         end
         FIRST, ACCUM: begin
            data_ready_out = 1'b1;
            if (data_valid_in) begin
               // The first operand bypasses the adder: only its sign may flip.
               if (state == FIRST)
                  acc_nxt = {data_in[DATA_WIDTH-1] ^ opcode_in, data_in[DATA_WIDTH-2:0]};
               else
                  acc_nxt = sum;
               if (&acc_nxt[DATA_WIDTH-2:MENT_WIDTH]) special_nxt = 1'b1;
               remaining_nxt = remaining - COUNT_WIDTH'(1);
               state_nxt     = (remaining == COUNT_WIDTH'(1)) ? DONE : ACCUM;
            end
         end
         DONE: begin
            result_valid_out = 1'b1;
            result_out       = acc;
            if (result_ready_in) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_out    = (state != IDLE);
   assign special_out = special;
endmodule
